// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_PASS = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_ASR  = 4'h9;
  localparam logic [3:0] OP_INC  = 4'hA;
  localparam logic [3:0] OP_DEC  = 4'hB;
  localparam logic [3:0] OP_SLT  = 4'hC;
  localparam logic [3:0] OP_ULT  = 4'hD;
  localparam logic [3:0] OP_MULL = 4'hE;
  localparam logic [3:0] OP_MULH = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULL) || (op == OP_MULH);
  endfunction

  function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                            input logic v, input logic n);
    logic [3:0] f;
    f        = '0;
    f[FLG_Z] = z;
    f[FLG_C] = c;
    f[FLG_V] = v;
    f[FLG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial-product step per clock, WIDTH steps per start.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH:0]     add_w;
  logic [2*WIDTH-1:0] step_w;

  // Upper half accumulates; the multiplier bits drain out of the lower half.
  always_comb begin
    add_w  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    step_w = {add_w, prod_q[WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        mcand_q <= multiplicand;
        prod_q  <= {{WIDTH{1'b0}}, multiplier};
        cnt_q   <= CW'(WIDTH);
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        prod_q <= step_w;
        cnt_q  <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: rtl/alu_seq.sv
// Registered 16-opcode ALU with valid/ready handshakes and a sequential multiplier.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [3:0]       flags
);
  import alu_pkg::*;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [3:0]         flags_q, flags_d;
  logic               mul_hi_q, mul_hi_d;

  logic               accept;
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] product;

  logic [WIDTH-1:0]   opnd_b;
  logic [WIDTH:0]     sum_w, diff_w;
  logic [WIDTH-1:0]   alu_x, mul_x;
  logic               alu_c, alu_v;
  logic [3:0]         alu_flags, mul_flags;

  assign in_ready  = !reset && !mul_busy &&
                     ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul(sel);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .reset        (reset),
    .start        (mul_start),
    .multiplicand (a),
    .multiplier   (b),
    .busy         (mul_busy),
    .done         (mul_done),
    .product      (product)
  );

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    alu_x  = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    opnd_b = ((sel == OP_INC) || (sel == OP_DEC)) ? WIDTH'(1) : b;
    sum_w  = {1'b0, a} + {1'b0, opnd_b};
    diff_w = {1'b0, a} - {1'b0, opnd_b};
    case (sel)
      OP_PASS: alu_x = a;
      OP_ADD, OP_INC: begin
        alu_x = sum_w[WIDTH-1:0];
        alu_c = sum_w[WIDTH];
        alu_v = (a[WIDTH-1] == opnd_b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        alu_x = diff_w[WIDTH-1:0];
        alu_c = diff_w[WIDTH];
        alu_v = (a[WIDTH-1] != opnd_b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_x = a & b;
      OP_OR:   alu_x = a | b;
      OP_XOR:  alu_x = a ^ b;
      OP_NOT:  alu_x = ~a;
      OP_SHL:  begin alu_x = {a[WIDTH-2:0], 1'b0};       alu_c = a[WIDTH-1]; end
      OP_SHR:  begin alu_x = {1'b0, a[WIDTH-1:1]};       alu_c = a[0];       end
      OP_ASR:  begin alu_x = {a[WIDTH-1], a[WIDTH-1:1]}; alu_c = a[0];       end
      OP_SLT:  alu_x = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_ULT:  alu_x = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_x = '0;
    endcase
    alu_flags = pack_flags(alu_x == '0, alu_c, alu_v, alu_x[WIDTH-1]);

    mul_x     = mul_hi_q ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
    mul_flags = pack_flags(mul_x == '0, 1'b0,
                           !mul_hi_q && (product[2*WIDTH-1:WIDTH] != '0),
                           mul_x[WIDTH-1]);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    flags_d  = flags_q;
    mul_hi_d = mul_hi_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (is_mul(sel)) begin
            state_d  = ST_MUL;
            mul_hi_d = (sel == OP_MULH);
          end else begin
            state_d = ST_DONE;
            x_d     = alu_x;
            flags_d = alu_flags;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_DONE;
          x_d     = mul_x;
          flags_d = mul_flags;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      flags_q  <= '0;
      mul_hi_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      flags_q  <= flags_d;
      mul_hi_q <= mul_hi_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign x         = x_q;
  assign flags     = flags_q;

endmodule
